// File: rtl/mem_wb_pipe_multi_if.sv
// MEM->WB bundle for the N-lane pipeline register; hold_* exists only with MEM_WB_HOLD_EN.
// master = MEM/hazard side driving mem_* and stall/flush, slave = the pipeline register.
interface mem_wb_pipe_multi_if #(
   parameter int unsigned LANES  = 2,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 32
);
   logic                     stall;
   logic                     flush;
   logic [LANES-1:0]         mem_valid;
   logic [LANES-1:0]         mem_we;
   logic [LANES*REG_AW-1:0]  mem_dest;
   logic [LANES*DATA_W-1:0]  mem_data;
   logic [LANES-1:0]         wb_valid;
   logic [LANES-1:0]         wb_we;
   logic [LANES*REG_AW-1:0]  wb_dest;
   logic [LANES*DATA_W-1:0]  wb_data;
   logic [CNT_W-1:0]         retire_cnt;
`ifdef MEM_WB_HOLD_EN
   logic [LANES-1:0]         hold_we;
   logic [LANES*REG_AW-1:0]  hold_dest;
   logic [LANES*DATA_W-1:0]  hold_data;

   modport master (
      output stall, flush, mem_valid, mem_we, mem_dest, mem_data,
      input  wb_valid, wb_we, wb_dest, wb_data, retire_cnt, hold_we, hold_dest, hold_data
   );
   modport slave (
      input  stall, flush, mem_valid, mem_we, mem_dest, mem_data,
      output wb_valid, wb_we, wb_dest, wb_data, retire_cnt, hold_we, hold_dest, hold_data
   );
`else
   modport master (
      output stall, flush, mem_valid, mem_we, mem_dest, mem_data,
      input  wb_valid, wb_we, wb_dest, wb_data, retire_cnt
   );
   modport slave (
      input  stall, flush, mem_valid, mem_we, mem_dest, mem_data,
      output wb_valid, wb_we, wb_dest, wb_data, retire_cnt
   );
`endif
endinterface

// File: rtl/mem_wb_pipe_multi.sv
// Multi-lane MEM->WB pipeline register with stall/flush, x0 suppression, same-cycle WAW
// resolution and retire counter. Define MEM_WB_HOLD_EN for the extra WB+1 hold stage.
module mem_wb_pipe_multi #(
   parameter int unsigned LANES  = 2,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 32
) (
   input logic                clk,
   input logic                reset,
   mem_wb_pipe_multi_if.slave bus
);

   logic [LANES-1:0]        kill;
   logic [LANES-1:0]        we_load;
   logic [CNT_W-1:0]        pop_cnt;

   logic [LANES-1:0]        valid_q;
   logic [LANES-1:0]        we_q;
   logic [LANES*REG_AW-1:0] dest_q;
   logic [LANES*DATA_W-1:0] data_q;
   logic [CNT_W-1:0]        cnt_q;

   // An older lane's write is killed when any younger lane writes the same register.
   always_comb begin
      kill    = '0;
      we_load = '0;
      pop_cnt = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         for (int unsigned j = i + 1; j < LANES; j++) begin
            if (bus.mem_valid[j] && bus.mem_we[j] &&
                (bus.mem_dest[j*REG_AW +: REG_AW] == bus.mem_dest[i*REG_AW +: REG_AW])) begin
               kill[i] = 1'b1;
            end
         end
         we_load[i] = bus.mem_valid[i] & bus.mem_we[i] &
                      (bus.mem_dest[i*REG_AW +: REG_AW] != '0) & ~kill[i];
         pop_cnt    = pop_cnt + CNT_W'(bus.mem_valid[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         we_q    <= '0;
         dest_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else if (!bus.stall) begin
         dest_q <= bus.mem_dest;
         data_q <= bus.mem_data;
         if (bus.flush) begin
            valid_q <= '0;
            we_q    <= '0;
         end else begin
            valid_q <= bus.mem_valid;
            we_q    <= we_load;
            cnt_q   <= cnt_q + pop_cnt;
         end
      end
   end

   assign bus.wb_valid   = valid_q;
   assign bus.wb_we      = we_q;
   assign bus.wb_dest    = dest_q;
   assign bus.wb_data    = data_q;
   assign bus.retire_cnt = cnt_q;

`ifdef MEM_WB_HOLD_EN
   logic [LANES-1:0]        hold_we_q;
   logic [LANES*REG_AW-1:0] hold_dest_q;
   logic [LANES*DATA_W-1:0] hold_data_q;

   // WB contents are already committed, so a flush does not stop the hold capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_we_q   <= '0;
         hold_dest_q <= '0;
         hold_data_q <= '0;
      end else if (!bus.stall) begin
         hold_we_q   <= we_q;
         hold_dest_q <= dest_q;
         hold_data_q <= data_q;
      end
   end

   assign bus.hold_we   = hold_we_q;
   assign bus.hold_dest = hold_dest_q;
   assign bus.hold_data = hold_data_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_multi.sv
// Scoreboard bench for mem_wb_pipe_multi: directed cases then random traffic vs. a lane-level model.
// Hold-stage checks are compiled in when MEM_WB_HOLD_EN is defined.
module tb_mem_wb_pipe_multi;
   localparam int unsigned L  = 2;
   localparam int unsigned DW = 32;
   localparam int unsigned RA = 5;
   localparam int unsigned CW = 32;

   typedef struct {
      logic [L-1:0]    valid;
      logic [L-1:0]    we;
      logic [L*RA-1:0] dest;
      logic [L*DW-1:0] data;
      logic [CW-1:0]   cnt;
      bit              dc;
      logic [L-1:0]    hwe;
      logic [L*RA-1:0] hdest;
      logic [L*DW-1:0] hdata;
      bit              hdc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   exp_t m;

   mem_wb_pipe_multi_if #(.LANES(L), .DATA_W(DW), .REG_AW(RA), .CNT_W(CW)) bus ();

   mem_wb_pipe_multi #(.LANES(L), .DATA_W(DW), .REG_AW(RA), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue the state expected after the next rise.
   task automatic step(input bit rst, input bit st, input bit fl, input logic [L-1:0] v,
                       input logic [L-1:0] w, input logic [L*RA-1:0] d,
                       input logic [L*DW-1:0] dat);
      int owner[32];
      int unsigned di;
      @(negedge clk);
      reset         = rst;
      bus.stall     = st;
      bus.flush     = fl;
      bus.mem_valid = v;
      bus.mem_we    = w;
      bus.mem_dest  = d;
      bus.mem_data  = dat;
      if (rst) begin
         m = '{valid: '0, we: '0, dest: '0, data: '0, cnt: '0, dc: 0,
               hwe: '0, hdest: '0, hdata: '0, hdc: 0};
      end else if (!st) begin
         m.hwe   = m.we;
         m.hdest = m.dest;
         m.hdata = m.data;
         m.hdc   = m.dc;
         m.dest  = d;
         m.data  = dat;
         if (fl) begin
            m.valid = '0;
            m.we    = '0;
            m.dc    = 1;
         end else begin
            // Youngest writer of each register wins: later lanes overwrite the owner entry.
            for (int k = 0; k < 32; k++) owner[k] = -1;
            for (int i = 0; i < int'(L); i++)
               if (v[i] && w[i]) owner[int'(d[i*RA +: RA])] = i;
            for (int i = 0; i < int'(L); i++) begin
               di      = d[i*RA +: RA];
               m.we[i] = v[i] && w[i] && di != 0 && owner[di] == i;
            end
            m.valid = v;
            m.dc    = 0;
            m.cnt   = m.cnt + CW'($countones(v));
         end
      end
      q.push_back(m);
   endtask

   task automatic rnd_step(input bit rst, input bit st, input bit fl);
      logic [L*RA-1:0] d;
      logic [L*DW-1:0] dat;
      for (int i = 0; i < int'(L); i++) begin
         d[i*RA +: RA]   = ($urandom_range(0, 3) == 0) ? RA'($urandom) : RA'($urandom_range(0, 3));
         dat[i*DW +: DW] = DW'($urandom);
      end
      step(rst, st, fl, L'($urandom), L'($urandom), d, dat);
   endtask

   // Monitor: the register presents a new WB bundle every cycle; check it against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("wb_valid", 256'(bus.wb_valid), 256'(e.valid));
            chk("wb_we", 256'(bus.wb_we), 256'(e.we));
            chk("retire_cnt", 256'(bus.retire_cnt), 256'(e.cnt));
            if (!e.dc) begin
               chk("wb_dest", 256'(bus.wb_dest), 256'(e.dest));
               chk("wb_data", 256'(bus.wb_data), 256'(e.data));
            end
`ifdef MEM_WB_HOLD_EN
            chk("hold_we", 256'(bus.hold_we), 256'(e.hwe));
            if (!e.hdc) begin
               chk("hold_dest", 256'(bus.hold_dest), 256'(e.hdest));
               chk("hold_data", 256'(bus.hold_data), 256'(e.hdata));
            end
`endif
         end
      end
   end

   initial begin
      int budget;
      reset         = 1'b1;
      bus.stall     = 1'b0;
      bus.flush     = 1'b0;
      bus.mem_valid = '1;
      bus.mem_we    = '1;
      bus.mem_dest  = {5'd9, 5'd4};
      bus.mem_data  = {32'h1234, 32'h5678};
      // Reset held two cycles with live inputs, then the first load.
      step(1, 0, 0, 2'b11, 2'b11, {5'd9, 5'd4}, {32'h1234, 32'h5678});
      step(1, 1, 1, 2'b11, 2'b11, {5'd9, 5'd4}, {32'h1234, 32'h5678});
      step(0, 0, 0, 2'b11, 2'b11, {5'd9, 5'd4}, {32'h1234, 32'h5678});
      // Two independent writers, then a same-register pair, then an x0 write.
      step(0, 0, 0, 2'b11, 2'b11, {5'd7, 5'd3}, {32'hBB, 32'hAA});
      step(0, 0, 0, 2'b11, 2'b11, {5'd5, 5'd5}, {32'h22, 32'h11});
      step(0, 0, 0, 2'b01, 2'b01, {5'd6, 5'd0}, {32'h44, 32'h33});
      step(0, 0, 0, 2'b10, 2'b11, {5'd8, 5'd8}, {32'h66, 32'h55});
      // Stall for three cycles with changing inputs, then stall together with flush.
      for (int k = 0; k < 3; k++) rnd_step(0, 1, 0);
      rnd_step(0, 1, 1);
      // Flush with both lanes valid, then a normal load so the hold stage captures flushed WB.
      step(0, 0, 1, 2'b11, 2'b11, {5'd2, 5'd1}, {32'hDD, 32'hCC});
      step(0, 0, 0, 2'b11, 2'b11, {5'd2, 5'd1}, {32'hDD, 32'hCC});
      step(0, 0, 0, 2'b00, 2'b00, {5'd0, 5'd0}, {32'h0, 32'h0});
      // Reset during a stall.
      step(0, 0, 0, 2'b11, 2'b11, {5'd3, 5'd3}, {32'h1, 32'h2});
      step(1, 1, 0, 2'b11, 2'b11, {5'd3, 5'd3}, {32'h1, 32'h2});
      step(0, 0, 0, 2'b11, 2'b10, {5'd3, 5'd3}, {32'h1, 32'h2});
      for (int k = 0; k < 400; k++)
         rnd_step($urandom_range(0, 49) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 6) == 0);
      budget = 10;
      while (q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
